pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline, sitting beside the execute-stage forwarding unit. It resolves the hazards forwarding cannot cover: load-use dependencies, multi-cycle execute operations, data-memory wait states and taken branches. It drives per-stage stall (hold) and flush (bubble) controls from one priority decision per cycle. It also runs a memory-wait watchdog.

## Interface
- N, 4, register ID width
- MC_CYCLES, 4, total cycles a multi-cycle op occupies execute (≥2)
- MEM_TIMEOUT, 16, consecutive memory-wait cycles before error (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- memtoreg_E  in  1  execute-stage instruction is a load
- Rd_E  in  N  execute destination register ID
- RegA_D, RegB_D  in  N  decode source register IDs
- useA_D, useB_D  in  1  decode actually reads RegA_D / RegB_D
- branch_taken_E  in  1  taken branch resolved in execute
- mc_start_E  in  1  multi-cycle op entering execute
- mem_req_M, mem_ready  in  1  memory access pending / data memory ready
- stall_F, stall_D, stall_E, stall_M  out  1  hold stage register
- flush_D, flush_E, flush_M, flush_W  out  1  insert bubble into stage register
- mc_busy  out  1  state == MC_BUSY
- mem_err  out  1  sticky watchdog error
- perf_stall_cnt, perf_lu_cnt  out  16  performance counters (see Configuration)

## Operation
- memwait = mem_req_M & ~mem_ready. loaduse = memtoreg_E & ((useA_D & RegA_D==Rd_E) | (useB_D & RegB_D==Rd_E)). No register is excluded; ID 0 is an ordinary register.
- FSM states: IDLE, MC_BUSY. Counter mc_cnt, width $clog2(MC_CYCLES).
- Per cycle, first matching rule applies; unlisted outputs are 0:
  1. memwait: stall_F/D/E/M=1, flush_W=1. FSM and mc_cnt hold.
  2. mcstall = (IDLE & mc_start_E) | (MC_BUSY & mc_cnt!=0): stall_F/D/E=1, flush_M=1.
  3. branch_taken_E: flush_D=1, flush_E=1. A branch overrides load-use, because the dependent instruction is squashed.
  4. loaduse: stall_F=1, stall_D=1, flush_E=1.
- Branch input is ignored under rules 1–2, because execute is held and the branch is re-evaluated.
- FSM transitions occur only when memwait=0:
  - IDLE & mc_start_E → MC_BUSY, mc_cnt ← MC_CYCLES-2.
  - MC_BUSY & mc_cnt!=0 → mc_cnt−1.
  - MC_BUSY & mc_cnt==0 → IDLE. Stalls are released this cycle; rules 3–4 are evaluated normally.
- Watchdog: wait_cnt counts consecutive memwait cycles, saturates at MEM_TIMEOUT, and clears when memwait=0. mem_err is set on the edge where wait_cnt reaches MEM_TIMEOUT. It is cleared only by rst and does not alter stalling.

## Timing
- Stall/flush outputs are combinational from inputs and registered state, with zero latency.
- While rst=1, all outputs are 0; state=IDLE, mc_cnt=0, wait_cnt=0, mem_err=0, perf counters 0.
- Reset asserted mid-operation aborts MC_BUSY immediately.
- mc_start_E at cycle t with no memwait:
  - stalls high t..t+MC_CYCLES-2, low at t+MC_CYCLES-1.
  - mc_busy high t+1..t+MC_CYCLES-1.
- Each memwait cycle extends the above by one cycle.
- mem_err rises on the clock edge ending the MEM_TIMEOUT-th consecutive memwait cycle.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_stall_cnt increments each cycle stall_F=1.
  - perf_lu_cnt increments each cycle rule 4 fires.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are tied to 16'h0000 and no counter logic is built.

## Structure
- Package hazard_pkg holds:
  - state enum (IDLE, MC_BUSY)
  - stage-control struct (stall/flush bits)
  - PERF_W=16 constant
- Sub-module hazard_sat_counter: saturating, enable-driven, async-reset counter parameterized by width. It is instantiated twice under HAZARD_PERF_EN.

## Test plan
- Load-use match: memtoreg_E=1, Rd_E=3, RegA_D=3, useA_D=1 → stall_F=stall_D=flush_E=1. With RegA_D=5, RegB_D=3, useB_D=0 → all outputs 0.
- Multi-cycle op, MC_CYCLES=4: mc_start_E pulse at t → stall_F/D/E and flush_M high t..t+2, low t+3; mc_busy high t+1..t+3.
- Memory wait inside MC_BUSY: mem_req_M=1, mem_ready=0 for 3 cycles at t+1 → stall_M, flush_W high 3 cycles; release moves to t+6.
- Simultaneous branch_taken_E and load-use → flush_D=flush_E=1, stall_F=stall_D=0.
- Watchdog: memwait held 16 cycles → mem_err=1 after 16th edge, stays 1 after mem_ready=1, clears on rst.
- Reset and performance counters:
  - rst asserted during MC_BUSY → all outputs 0 asynchronously; after release, state IDLE.
  - With HAZARD_PERF_EN, 70000 stall cycles → perf_stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, per-stage control bundle, counter width.
// Purpose: common definitions | Latency: n/a | Backpressure: n/a
package hazard_pkg;

    localparam int PERF_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter, increments when en=1 and holds at all-ones.
// Latency: count visible the cycle after en | Backpressure: none, saturates instead of wrapping
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline plus memory-wait watchdog; perf counters under HAZARD_PERF_EN.
// Latency: controls are combinational (zero cycles) | Backpressure: memwait holds F..M and bubbles W
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int N           = 4,
    parameter int MC_CYCLES   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memtoreg_E,
    input  logic [N-1:0]      Rd_E,
    input  logic [N-1:0]      RegA_D,
    input  logic [N-1:0]      RegB_D,
    input  logic              useA_D,
    input  logic              useB_D,
    input  logic              branch_taken_E,
    input  logic              mc_start_E,
    input  logic              mem_req_M,
    input  logic              mem_ready,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              stall_M,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic              flush_W,
    output logic              mc_busy,
    output logic              mem_err,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_lu_cnt
);

    localparam int CW = $clog2(MC_CYCLES);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] MC_INIT = CW'(MC_CYCLES - 2);
    localparam logic [WW-1:0] TO_VAL  = WW'(MEM_TIMEOUT);

    hz_state_t   state_q, state_d;
    logic [CW-1:0] mc_cnt_q, mc_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic        memwait, loaduse, mcstall, lu_fire;
    stage_ctrl_t ctrl, ctrl_o;

    assign memwait = mem_req_M & ~mem_ready;
    assign loaduse = memtoreg_E & ((useA_D & (RegA_D == Rd_E)) | (useB_D & (RegB_D == Rd_E)));
    assign mcstall = ((state_q == IDLE) & mc_start_E) | ((state_q == MC_BUSY) & (mc_cnt_q != '0));

    always_comb begin
        ctrl     = '0;
        lu_fire  = 1'b0;
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        if (memwait) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
            ctrl.flush_w = 1'b1;
        end else if (mcstall) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.flush_m = 1'b1;
        end else if (branch_taken_E) begin
            // The load-use consumer sits in decode and is squashed, so no stall is needed.
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else if (loaduse) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
            lu_fire      = 1'b1;
        end

        if (!memwait) begin
            case (state_q)
                IDLE: begin
                    if (mc_start_E) begin
                        state_d  = MC_BUSY;
                        mc_cnt_d = MC_INIT;
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt_q != '0) begin
                        mc_cnt_d = mc_cnt_q - CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (memwait) begin
            wait_cnt_d = (wait_cnt_q == TO_VAL) ? wait_cnt_q : wait_cnt_q + WW'(1);
        end
        mem_err_d = mem_err_q | (memwait & (wait_cnt_q == TO_VAL - WW'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mc_cnt_q   <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mc_cnt_q   <= mc_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Reset must force every output low even though the controls are combinational from inputs.
    assign ctrl_o  = rst ? '0 : ctrl;
    assign stall_F = ctrl_o.stall_f;
    assign stall_D = ctrl_o.stall_d;
    assign stall_E = ctrl_o.stall_e;
    assign stall_M = ctrl_o.stall_m;
    assign flush_D = ctrl_o.flush_d;
    assign flush_E = ctrl_o.flush_e;
    assign flush_M = ctrl_o.flush_m;
    assign flush_W = ctrl_o.flush_w;
    assign mc_busy = ~rst & (state_q == MC_BUSY);
    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    hazard_sat_counter #(.W(PERF_W)) u_perf_stall (
        .clk (clk),
        .rst (rst),
        .en  (ctrl_o.stall_f),
        .cnt (perf_stall_cnt)
    );

    hazard_sat_counter #(.W(PERF_W)) u_perf_lu (
        .clk (clk),
        .rst (rst),
        .en  (lu_fire & ~rst),
        .cnt (perf_lu_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_lu_cnt    = '0;
`endif

endmodule
